// File: rtl/mcp3202_conv_scheduler.sv
// Frame-rate conversion sequencer: per-frame CH0/CH1 requests to the SPI engine, tagged results to AXIS via a 2-deep FIFO.
// Latency: tick -> conv_start next cycle; conv_done -> tvalid next cycle when the FIFO was empty.
// Backpressure: tready stalls the FIFO head; a result arriving with the FIFO full and no pop is dropped and flagged (overrun).
module mcp3202_conv_scheduler #(
   parameter int         FCLK    = 100_000_000,
   parameter int         FSMPL   = 200,
   parameter logic [1:0] CH_MASK = 2'b11,
   parameter bit         SGL     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        conv_start,
   output logic        conv_sgl,
   output logic        conv_odd,
   input  logic        conv_done,
   input  logic [11:0] conv_data,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        overrun,
   output logic        frame_miss,
   input  logic        clr_flags
);

   localparam int FRAME_CNT = FCLK / FSMPL;
   localparam int CW        = (FRAME_CNT > 1) ? $clog2(FRAME_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CNT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_NEXT  = 2'd3;

   typedef struct packed {
      logic        ch;
      logic [11:0] data;
   } entry_t;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_state;
   logic          r_ch;
   entry_t        r_head;
   entry_t        r_tail;
   logic [1:0]    r_fcnt;
   logic          r_overrun;
   logic          r_frame_miss;

   logic   w_tick;
   logic   w_active;
   logic   w_wr;
   logic   w_pop;
   logic   w_full;
   logic   w_acc;
   logic   w_drop;
   logic   w_miss;
   entry_t w_wdat;

   // Frame timer only runs while enabled, so re-enabling always starts a full frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!enable || r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_tick = (r_cnt == CNT_LAST) && enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ch    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_tick && CH_MASK != 2'b00) begin
                  r_state <= S_ISSUE;
                  r_ch    <= ~CH_MASK[0];
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               if (conv_done) begin
                  r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (!r_ch && CH_MASK[1] && enable) begin
                  r_state <= S_ISSUE;
                  r_ch    <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign conv_start = (r_state == S_ISSUE);
   assign conv_odd   = w_active & r_ch;
   assign conv_sgl   = w_active & SGL;

   assign w_wr   = (r_state == S_WAIT) && conv_done;
   assign w_wdat = '{ch: r_ch, data: conv_data};
   assign w_pop  = (r_fcnt != 2'd0) && m_axis_tready;
   assign w_full = (r_fcnt == 2'd2);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_acc  = w_wr && (!w_full || w_pop);
   assign w_drop = w_wr && w_full && !w_pop;
   assign w_miss = w_tick && (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_fcnt <= 2'd0;
      end else if (w_pop && w_acc) begin
         if (r_fcnt == 2'd1) begin
            r_head <= w_wdat;
         end else begin
            r_head <= r_tail;
            r_tail <= w_wdat;
         end
      end else if (w_pop) begin
         r_head <= r_tail;
         r_fcnt <= r_fcnt - 2'd1;
      end else if (w_acc) begin
         if (r_fcnt == 2'd0) begin
            r_head <= w_wdat;
         end else begin
            r_tail <= w_wdat;
         end
         r_fcnt <= r_fcnt + 2'd1;
      end
   end

   assign m_axis_tvalid = (r_fcnt != 2'd0);
   assign m_axis_tdata  = {3'b000, r_head.ch, r_head.data};

   // Set events win over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun    <= 1'b0;
         r_frame_miss <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (clr_flags) begin
            r_overrun <= 1'b0;
         end
         if (w_miss) begin
            r_frame_miss <= 1'b1;
         end else if (clr_flags) begin
            r_frame_miss <= 1'b0;
         end
      end
   end

   assign overrun    = r_overrun;
   assign frame_miss = r_frame_miss;

endmodule

// File: tb/tb_mcp3202_conv_scheduler.sv
// Directed bench: two schedulers (CH_MASK 11 and 10) driven by a fixed-delay SPI engine model.
module tb_mcp3202_conv_scheduler;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        clr_flags;

   logic        a_start, a_sgl, a_odd, a_done, a_tvalid, a_tready, a_overrun, a_fmiss;
   logic [11:0] a_data;
   logic [15:0] a_tdata;
   logic        b_start, b_sgl, b_odd, b_done, b_tvalid, b_tready, b_overrun, b_fmiss;
   logic [11:0] b_data;
   logic [15:0] b_tdata;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int delay = 20;

   bit a_busy, b_busy, a_odd_l, b_odd_l;
   int a_rem, b_rem;
   int a_starts[$];
   int b_starts[$];
   int a_beats[$];
   int b_beats[$];

   mcp3202_conv_scheduler #(.FCLK(1000), .FSMPL(100), .CH_MASK(2'b11), .SGL(1'b1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable),
      .conv_start(a_start), .conv_sgl(a_sgl), .conv_odd(a_odd),
      .conv_done(a_done), .conv_data(a_data),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
      .overrun(a_overrun), .frame_miss(a_fmiss), .clr_flags(clr_flags)
   );

   mcp3202_conv_scheduler #(.FCLK(1000), .FSMPL(100), .CH_MASK(2'b10), .SGL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .conv_start(b_start), .conv_sgl(b_sgl), .conv_odd(b_odd),
      .conv_done(b_done), .conv_data(b_data),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
      .overrun(b_overrun), .frame_miss(b_fmiss), .clr_flags(clr_flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Advance one cycle; beats are captured before the edge they are accepted on.
   task automatic step();
      bit a_fire, b_fire;
      int a_d, b_d;
      a_fire = a_tvalid && a_tready;
      b_fire = b_tvalid && b_tready;
      a_d = int'(a_tdata);
      b_d = int'(b_tdata);
      @(negedge clk);
      cyc++;
      if (a_fire) a_beats.push_back(a_d);
      if (b_fire) b_beats.push_back(b_d);
      a_done = 1'b0;
      if (a_busy) begin
         a_rem--;
         if (a_rem == 0) begin
            a_done = 1'b1;
            a_data = a_odd_l ? 12'h123 : 12'hABC;
            a_busy = 1'b0;
         end
      end
      if (a_start) begin
         a_busy = 1'b1; a_rem = delay; a_odd_l = a_odd;
         a_starts.push_back(cyc);
      end
      b_done = 1'b0;
      if (b_busy) begin
         b_rem--;
         if (b_rem == 0) begin
            b_done = 1'b1;
            b_data = b_odd_l ? 12'h123 : 12'hABC;
            b_busy = 1'b0;
         end
      end
      if (b_start) begin
         b_busy = 1'b1; b_rem = delay; b_odd_l = b_odd;
         b_starts.push_back(cyc);
         chk("b_req_odd", 32'(b_odd), 32'd1);
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic clear_q();
      a_starts.delete(); b_starts.delete();
      a_beats.delete(); b_beats.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_busy = 1'b0; b_busy = 1'b0;
      a_done = 1'b0; b_done = 1'b0;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
      clear_q();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; clr_flags = 1'b0;
      a_tready = 1'b1; b_tready = 1'b1;
      a_done = 1'b0; b_done = 1'b0; a_data = 12'h0; b_data = 12'h0;
      a_busy = 1'b0; b_busy = 1'b0; a_rem = 0; b_rem = 0;

      // Reset state and basic two-channel frame
      step();
      step();
      chk("rst_start", 32'(a_start), 32'd0);
      chk("rst_tvalid", 32'(a_tvalid), 32'd0);
      chk("rst_tdata", 32'(a_tdata), 32'd0);
      chk("rst_overrun", 32'(a_overrun), 32'd0);
      chk("rst_fmiss", 32'(a_fmiss), 32'd0);
      chk("rst_odd", 32'(a_odd), 32'd0);
      chk("rst_sgl", 32'(a_sgl), 32'd0);
      chk("rst_b_tvalid", 32'(b_tvalid), 32'd0);
      rst = 1'b0; cyc = 0; clear_q();
      run_to(20);
      chk("wait_odd", 32'(a_odd), 32'd0);
      chk("wait_sgl", 32'(a_sgl), 32'd1);
      run_to(30);
      chk("tvalid_at_done", 32'(a_tvalid), 32'd0);
      run_to(31);
      chk("tvalid_done_p1", 32'(a_tvalid), 32'd1);
      chk("tdata_ch0", 32'(a_tdata), 32'h0ABC);
      run_to(56);
      chk("a_nstarts", 32'(a_starts.size()), 32'd2);
      chk("a_start0", 32'(qat(a_starts, 0)), 32'd10);
      chk("a_start1", 32'(qat(a_starts, 1)), 32'd32);
      chk("a_nbeats", 32'(a_beats.size()), 32'd2);
      chk("a_beat0", 32'(qat(a_beats, 0)), 32'h0ABC);
      chk("a_beat1", 32'(qat(a_beats, 1)), 32'h1123);
      chk("a_fmiss_busy", 32'(a_fmiss), 32'd1);
      chk("b_nstarts", 32'(b_starts.size()), 32'd2);
      chk("b_start1", 32'(qat(b_starts, 1)), 32'd40);
      chk("b_nbeats", 32'(b_beats.size()), 32'd1);
      chk("b_beat0_ch", 32'((qat(b_beats, 0) >> 12) & 1), 32'd1);
      chk("b_beat0", 32'(qat(b_beats, 0)), 32'h1123);

      // Backpressure: three results into a 2-deep FIFO
      a_tready = 1'b0;
      do_reset();
      run_to(54);
      chk("bp_tvalid", 32'(a_tvalid), 32'd1);
      chk("bp_tdata_hold", 32'(a_tdata), 32'h0ABC);
      run_to(80);
      chk("bp_overrun_pre", 32'(a_overrun), 32'd0);
      run_to(81);
      chk("bp_overrun", 32'(a_overrun), 32'd1);
      chk("bp_tdata_hold2", 32'(a_tdata), 32'h0ABC);
      enable = 1'b0;
      a_tready = 1'b1;
      run_to(90);
      chk("bp_nbeats", 32'(a_beats.size()), 32'd2);
      chk("bp_beat0", 32'(qat(a_beats, 0)), 32'h0ABC);
      chk("bp_beat1", 32'(qat(a_beats, 1)), 32'h1123);
      chk("bp_drained", 32'(a_tvalid), 32'd0);
      chk("bp_nstarts", 32'(a_starts.size()), 32'd3);
      chk("bp_overrun_sticky", 32'(a_overrun), 32'd1);

      // Frame miss with 15-cycle engine, enable drop during ch0 wait, flag clear
      delay = 15;
      enable = 1'b1;
      do_reset();
      run_to(18);
      chk("fm_pre", 32'(a_fmiss), 32'd0);
      run_to(20);
      chk("fm_set", 32'(a_fmiss), 32'd1);
      run_to(21);
      enable = 1'b0;
      run_to(35);
      chk("en_nstarts", 32'(a_starts.size()), 32'd1);
      chk("en_nbeats", 32'(a_beats.size()), 32'd1);
      chk("en_beat0", 32'(qat(a_beats, 0)), 32'h0ABC);
      chk("fm_hold", 32'(a_fmiss), 32'd1);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("fm_clr", 32'(a_fmiss), 32'd0);
      chk("ov_clr", 32'(a_overrun), 32'd0);
      enable = 1'b1;
      run_to(50);
      chk("reen_nstarts", 32'(a_starts.size()), 32'd2);
      chk("reen_start", 32'(qat(a_starts, 1)), 32'd46);
      enable = 1'b0;

      // Reset pulse during WAIT; the late conv_done must be ignored
      delay = 20;
      enable = 1'b1;
      do_reset();
      run_to(28);
      chk("ab_in_wait_odd", 32'(a_sgl), 32'd1);
      rst = 1'b1;
      step();
      chk("ab_start", 32'(a_start), 32'd0);
      chk("ab_tvalid", 32'(a_tvalid), 32'd0);
      chk("ab_sgl", 32'(a_sgl), 32'd0);
      rst = 1'b0; cyc = 0; clear_q();
      run_to(9);
      chk("ab_nstarts_pre", 32'(a_starts.size()), 32'd0);
      chk("ab_late_done", 32'(a_tvalid), 32'd0);
      run_to(12);
      chk("ab_nstarts", 32'(a_starts.size()), 32'd1);
      chk("ab_start0", 32'(qat(a_starts, 0)), 32'd10);
      chk("ab_nbeats", 32'(a_beats.size()), 32'd0);
      chk("ab_overrun", 32'(a_overrun), 32'd0);
      chk("ab_fmiss", 32'(a_fmiss), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
